// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit CLA slice per stage, registered inter-slice carry.
// Optional signed-overflow output is enabled with the CLA_OVF_EN macro.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int  BLK_SAFE = (BLK >= 1) ? BLK : 1;
  localparam int  STAGES   = (BLK >= 1) ? (WIDTH / BLK_SAFE) : 1;
  localparam bit  CFG_OK   = (BLK >= 1) && (WIDTH >= 1) && ((WIDTH % BLK_SAFE) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK, BLK >= 1");
  end

  // Lookahead slice: each carry is a flat sum of generate/propagate products, no ripple chain.
  function automatic logic [BLK_SAFE:0] cla_slice(input logic [BLK_SAFE-1:0] x,
                                                  input logic [BLK_SAFE-1:0] y,
                                                  input logic              ci);
    logic [BLK_SAFE-1:0] g;
    logic [BLK_SAFE-1:0] p;
    logic [BLK_SAFE:0]   c;
    logic                prod;
    g    = x & y;
    p    = x ^ y;
    c    = {(BLK_SAFE+1){1'b0}};
    c[0] = ci;
    prod = 1'b0;
    for (int i = 0; i < BLK_SAFE; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & ci);
    end
    return {c[BLK_SAFE], p ^ c[BLK_SAFE-1:0]};
  endfunction

  // x_r[k]: result slices below k already summed, operand A slices from k upward still raw.
  logic                v_r [0:STAGES];
  logic                c_r [0:STAGES];
  logic [WIDTH-1:0]    x_r [0:STAGES];
  logic [WIDTH-1:0]    y_r [0:STAGES-1];
  logic [BLK_SAFE-1:0] ssum_s [0:STAGES-1];
  logic                sco_s  [0:STAGES-1];
  logic [WIDTH-1:0]    xn_s   [0:STAGES-1];
  logic                stall_s;

  assign stall_s   = v_r[STAGES] && !out_ready;
  assign in_ready  = !stall_s && !rst;
  assign out_valid = v_r[STAGES];
  assign sum       = x_r[STAGES];
  assign cout      = c_r[STAGES];

  // Per-stage slice evaluation and splice of the new sum slice into the travelling word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      {sco_s[k], ssum_s[k]} = cla_slice(x_r[k][k*BLK_SAFE +: BLK_SAFE],
                                        y_r[k][k*BLK_SAFE +: BLK_SAFE], c_r[k]);
      xn_s[k] = x_r[k];
      xn_s[k][k*BLK_SAFE +: BLK_SAFE] = ssum_s[k];
    end
  end

  // Pipeline advance; the whole pipe freezes while the output beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        x_r[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k < STAGES; k++) begin
        y_r[k] <= {WIDTH{1'b0}};
      end
`ifdef CLA_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (!stall_s) begin
      v_r[0] <= in_valid;
      x_r[0] <= a;
      y_r[0] <= sub ? ~b : b;
      c_r[0] <= sub ? 1'b1 : cin;
      for (int k = 0; k < STAGES; k++) begin
        v_r[k+1] <= v_r[k];
        c_r[k+1] <= sco_s[k];
        x_r[k+1] <= xn_s[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        y_r[k] <= y_r[k-1];
      end
`ifdef CLA_OVF_EN
      // carry into MSB recovered from the MSB operand bits and its sum bit
      ovf <= x_r[STAGES-1][WIDTH-1] ^ y_r[STAGES-1][WIDTH-1]
           ^ ssum_s[STAGES-1][BLK_SAFE-1] ^ sco_s[STAGES-1];
`endif
    end else begin
      v_r[0] <= v_r[0];
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised pipelined carry-lookahead adder/subtractor. It is the successor to the single-cycle 4-bit dataflow CLA.
- Splits a WIDTH-bit operation into BLK-bit CLA slices, one slice per pipeline stage.
- The carry is registered between stages.
- Sustains one operation per clock, with a valid/ready handshake on both sides.
- Used wherever wide adds must close timing at high clock rates.

Parameters:
WIDTH, 16, operand/result width in bits; must be a positive multiple of BLK
BLK, 4, slice width handled by one internal CLA stage; must be >= 1
STAGES, WIDTH/BLK, derived (localparam), pipeline depth in cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  adder can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = add, 1 = subtract (a - b)
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; in subtract mode 1 = no borrow

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, sum, cout and ovf are cleared to 0 on that edge. out_valid=0 from that edge. In-flight operations are discarded, never emitted. in_ready=0 while rst is high.
- Effective operands: beff = sub ? ~b : b; c0 = sub ? 1 : cin (cin is ignored when sub=1).
- Acceptance: a beat is taken when in_valid && in_ready at a clk edge. a, beff and c0 are captured at stage 0.
- Stage k (0..STAGES-1) computes slice k, bits [k*BLK +: BLK], with generate/propagate lookahead from the carry registered by stage k-1.
  - Stage k registers the slice sum, the slice carry-out, and the not-yet-processed upper operand slices.
  - Lower result slices already computed are carried along, skewed, so all slices of one operation emerge together.
- Latency: exactly STAGES cycles from the acceptance edge to out_valid=1, absent stalls.
- Throughput: one beat per cycle; back-to-back acceptance is allowed.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall && !rst.
  - While stall is high, every pipeline register, including sum/cout/ovf, holds its value.
  - No beat is lost, duplicated or reordered.
- Output hold: sum and cout stay stable while out_valid && !out_ready.
- Bubbles: when in_valid=0 on an acceptance cycle, a bubble (valid=0) enters. Bubbles advance normally and do not stall.
- Width rules:
  - Result is modulo 2^WIDTH; cout is bit WIDTH of a + beff + c0.
  - WIDTH not a multiple of BLK, or BLK < 1, causes an elaboration failure.
- Degenerate case BLK=WIDTH: STAGES=1, latency 1 cycle, same handshake.

Optional Feature:
Macro CLA_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the operation actually performed.
  - ovf = carry into MSB XOR carry out of MSB.
  - ovf is registered alongside sum, resets to 0, and holds during stall.
- Undefined: no ovf port and no associated logic; all other behaviour is identical.

Test Plan:
Default WIDTH=16, BLK=4, STAGES=4 throughout.

1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, in_ready=0 throughout; no result ever emitted from those beats.
2. Add: a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x5555, cout=0, for one cycle.
3. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
4. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0 (cin ignored).
   - a=0x0009, b=0x0002, sub=1 -> sum=0x0007, cout=1.
   - With CLA_OVF_EN: a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1.
   - With CLA_OVF_EN: a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1.
5. Streaming with backpressure: 8 back-to-back beats (a=i, b=0x0100*i, i=1..8), out_ready=0 for 3 cycles once the first result appears:
   - in_ready=0 and sum held stable during the stall.
   - All 8 results appear in order with sum=0x0101*i.
   - Total cycles = 4 + 8 - 1 + 3.
6. Reset mid-operation: accept 2 beats, assert rst one cycle after the second acceptance, release, then accept a=0x0001, b=0x0001 -> only one result observed, sum=0x0002, 4 cycles after its acceptance.
